// File: rtl/instr_encoder.sv
// Encodes decoded operation requests into 32-bit MIPS words and queues them
// in a show-ahead FIFO that the fetch stage drains over a valid/ready handshake.
module instr_encoder #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4:0]               in_op,
  input  logic [4:0]               in_rs,
  input  logic [4:0]               in_rt,
  input  logic [4:0]               in_rd,
  input  logic [4:0]               in_shamt,
  input  logic [25:0]              in_imm,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [4:0] OP_ADD     = 5'd0;
  localparam logic [4:0] OP_ADDU    = 5'd1;
  localparam logic [4:0] OP_AND     = 5'd2;
  localparam logic [4:0] OP_JR      = 5'd3;
  localparam logic [4:0] OP_OR      = 5'd4;
  localparam logic [4:0] OP_SLL     = 5'd5;
  localparam logic [4:0] OP_SLT     = 5'd6;
  localparam logic [4:0] OP_SUB     = 5'd7;
  localparam logic [4:0] OP_SYSCALL = 5'd8;
  localparam logic [4:0] OP_ADDI    = 5'd9;
  localparam logic [4:0] OP_LUI     = 5'd10;
  localparam logic [4:0] OP_ADDIU   = 5'd11;
  localparam logic [4:0] OP_ORI     = 5'd12;
  localparam logic [4:0] OP_LW      = 5'd13;
  localparam logic [4:0] OP_SW      = 5'd14;
  localparam logic [4:0] OP_BEQ     = 5'd15;
  localparam logic [4:0] OP_BNE     = 5'd16;
  localparam logic [4:0] OP_J       = 5'd17;
  localparam logic [4:0] OP_JAL     = 5'd18;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_JAL   = 6'h03;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ADDIU = 6'h09;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_LUI   = 6'h0F;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  localparam logic [31:0] SYSCALL_WORD = 32'h0000000C;

  function automatic logic [31:0] rType(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] shamt,
                                        input logic [5:0] funct);
    return {6'h00, rs, rt, rd, shamt, funct};
  endfunction

  function automatic logic [31:0] iType(input logic [5:0] opc, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

  logic [31:0]   encWord;
  logic          legalOp;
  logic          accept;
  logic          push;
  logic          pop;

  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;
  logic [31:0]   mem [DEPTH];

  // Unused fields are forced to zero so the stored word is canonical for each op.
  always_comb begin
    encWord = 32'h0;
    legalOp = 1'b1;
    case (in_op)
      OP_ADD:     encWord = rType(in_rs, in_rt, in_rd, 5'd0, FN_ADD);
      OP_ADDU:    encWord = rType(in_rs, in_rt, in_rd, 5'd0, FN_ADDU);
      OP_AND:     encWord = rType(in_rs, in_rt, in_rd, 5'd0, FN_AND);
      OP_JR:      encWord = rType(in_rs, 5'd0, 5'd0, 5'd0, FN_JR);
      OP_OR:      encWord = rType(in_rs, in_rt, in_rd, 5'd0, FN_OR);
      OP_SLL:     encWord = rType(5'd0, in_rt, in_rd, in_shamt, FN_SLL);
      OP_SLT:     encWord = rType(in_rs, in_rt, in_rd, 5'd0, FN_SLT);
      OP_SUB:     encWord = rType(in_rs, in_rt, in_rd, 5'd0, FN_SUB);
      OP_SYSCALL: encWord = SYSCALL_WORD;
      OP_ADDI:    encWord = iType(OPC_ADDI, in_rs, in_rt, in_imm[15:0]);
      OP_LUI:     encWord = iType(OPC_LUI, 5'd0, in_rt, in_imm[15:0]);
      OP_ADDIU:   encWord = iType(OPC_ADDIU, in_rs, in_rt, in_imm[15:0]);
      OP_ORI:     encWord = iType(OPC_ORI, in_rs, in_rt, in_imm[15:0]);
      OP_LW:      encWord = iType(OPC_LW, in_rs, in_rt, in_imm[15:0]);
      OP_SW:      encWord = iType(OPC_SW, in_rs, in_rt, in_imm[15:0]);
      OP_BEQ:     encWord = iType(OPC_BEQ, in_rs, in_rt, in_imm[15:0]);
      OP_BNE:     encWord = iType(OPC_BNE, in_rs, in_rt, in_imm[15:0]);
      OP_J:       encWord = {OPC_J, in_imm};
      OP_JAL:     encWord = {OPC_JAL, in_imm};
      default:    legalOp = 1'b0;
    endcase
  end

  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign out_instr = mem[rdPtr_q];
  assign count     = count_q;
  assign err       = err_q;

  assign accept = in_valid && in_ready;
  assign push   = accept && legalOp;
  assign pop    = out_valid && out_ready;

  // Flush wins over everything; an illegal request is still consumed but only flags err.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    err_d   = 1'b0;
    if (flush) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (push) wrPtr_d = wrPtr_q + AW'(1);
      if (pop)  rdPtr_d = rdPtr_q + AW'(1);
      if (push && !pop) count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
      err_d = accept && !legalOp;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Storage is deliberately not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wrPtr_q] <= encWord;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Encodes decoded operation requests back into 32-bit MIPS instruction words and queues them for the fetch stage; it is the encoding counterpart of the control decoder. Used by the boot loader and self-test injector to stream instructions into the pipeline without instruction memory. Requests enter on a valid/ready handshake, are encoded combinationally, written into a DEPTH-entry FIFO, and drained by fetch on a second valid/ready handshake.

## Interface
- DEPTH, 8, FIFO entries; power of two, at least 2.
- clk  input  1  rising-edge clock.
- rst_b  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous FIFO clear; takes priority over push and pop.
- in_valid  input  1  request present.
- in_ready  output  1  request accepted this cycle when in_valid && in_ready.
- in_op  input  5  operation select: 0 ADD, 1 ADDU, 2 AND, 3 JR, 4 OR, 5 SLL, 6 SLT, 7 SUB, 8 SYSCALL, 9 ADDI, 10 LUI, 11 ADDIU, 12 ORI, 13 LW, 14 SW, 15 BEQ, 16 BNE, 17 J, 18 JAL; 19–31 illegal.
- in_rs, in_rt, in_rd  input  5 each  register fields.
- in_shamt  input  5  shift amount (SLL only).
- in_imm  input  26  imm16 in [15:0] for I-type; target in [25:0] for J/JAL.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  fetch consumes head when out_valid && out_ready.
- out_instr  output  32  FIFO head instruction word.
- count  output  $clog2(DEPTH)+1  current occupancy.
- err  output  1  one-cycle pulse: illegal in_op was accepted and dropped.

## Operation
- R-type word {6'h00, rs, rt, rd, shamt, funct}; fields not used by the op are forced to 0.
  - ADD 0x20, ADDU 0x21, AND 0x24, OR 0x25, SLT 0x2A, SUB 0x22: rs, rt, rd; shamt 0.
  - SLL 0x00: rt, rd, shamt; rs 0.
  - JR 0x08: rs only.
  - SYSCALL: constant 32'h0000000C.
- I-type word {opcode, rs, rt, imm[15:0]}: ADDI 0x08, ADDIU 0x09, ORI 0x0D, LW 0x23, SW 0x2B, BEQ 0x04, BNE 0x05. LUI 0x0F forces rs to 0.
- J-type word {opcode, imm[25:0]}: J 0x02, JAL 0x03.
- Push: in_valid && in_ready && legal op → encoded word is written at the write pointer, which then increments.
- Illegal op with in_valid && in_ready: the request is consumed, nothing is written, and err pulses on the next cycle.
- Pop: out_valid && out_ready → the read pointer increments.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH; full and empty are derived from count.
- in_ready = (count != DEPTH). out_valid = (count != 0). out_instr = mem[rd_ptr] (show-ahead).
- Simultaneous push and pop: count is unchanged and both pointers advance; this is legal only when count is between 1 and DEPTH-1.
- Empty: no bypass. A word pushed into an empty FIFO is not visible in the same cycle.
- flush: count, rd_ptr, wr_ptr and err all go to 0; any concurrent push or pop is ignored.

## Timing
- Reset (rst_b low, asynchronous): count 0, pointers 0, err 0, out_valid 0, in_ready 1. out_instr is don't-care while out_valid is 0. Memory contents are not reset.
- Reset asserted mid-stream discards all queued words immediately. No partial entry survives.
- Latency: a word accepted at edge N is presented with out_valid high after edge N, so it is consumable at edge N+1.
- Throughput: one push and one pop per cycle in steady state.
- in_ready and out_valid depend only on registered count; there is no combinational path from in_valid or out_ready to either.
- err is registered and high for exactly one cycle per dropped request.

## Test plan
- Reset, then push ADD (rs=1, rt=2, rd=3) → out_instr 32'h00221820 one cycle later; count 1.
- Push LUI (rs=7, rt=4, imm=16'h1234), then JAL (imm=26'h0100000) → out_instr 32'h3C041234, then 32'h0C100000 on consecutive pops.
- Push 8 words with out_ready=0 → in_ready drops after the 8th accept and count = 8. Ninth request is stalled. One pop then frees one slot, in_ready rises, and words drain in order through pointer wrap.
- At count = 3, push SW and pop in the same cycle → count stays 3; drained order is preserved.
- Push in_op = 25 → nothing enqueued, count unchanged, err high for exactly one cycle.
- Fill to 5, then assert flush together with push and pop → count 0, out_valid 0. Separately, pulse rst_b low mid-stream (asynchronous, between edges) → count 0 immediately.
